// File: rtl/serial_tx.sv
// serial_tx: serial frame transmitter.
// Frame: start bit (0), DATA_W data bits LSB-first, optional even parity bit,
// stop bit (1). Each bit lasts CLK_PER_BIT clocks. tx, busy and done are
// registered and decoded from next-state values, so they line up with the state.
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module serial_tx #(
    parameter int CLK_PER_BIT = 16,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q,    tx_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              bit_end_s;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;

    // Even parity over the latched word: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    assign bit_end_s = (cnt_q == CNT_LAST);

    // Frame sequencing: state, baud counter, bit index, shift register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_START;
                    cnt_d    = CNT_ZERO;
                    idx_d    = IDX_ZERO;
                    shift_d  = data_in;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = even_parity(data_in);
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = IDX_ZERO;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    state_d = S_STOP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
            end
        endcase
    end

    // Output decode from next state so registered outputs match the new state.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset to an idle line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            idx_q    <= IDX_ZERO;
            shift_q  <= {DATA_W{1'b0}};
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed testbench for serial_tx (CLK_PER_BIT=4, DATA_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB  = DW + 3;
`else
    localparam int NB  = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] data_in;
    logic          tx;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    int frame_no = 0;

    serial_tx #(.CLK_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " tx"},   tx,   1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
    endtask

    // Pulse start for one cycle; returns at the negedge after the capturing edge.
    task automatic start_pulse(input logic [DW-1:0] d);
        start   = 1'b1;
        data_in = d;
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'h00;
    endtask

    // Check a whole frame starting at the first START cycle. inject >= 0 raises
    // start with 0x3C at that cycle; chain starts the next frame in the done cycle.
    task automatic check_frame(input logic [DW-1:0] d, input int inject,
                               input logic chain, input logic [DW-1:0] nd);
        logic fb [NB];
        fb[0] = 1'b0;
        for (int i = 0; i < DW; i++) fb[1+i] = d[i];
`ifdef SERIAL_TX_PARITY_EN
        fb[DW+1] = ^d;
`endif
        fb[NB-1] = 1'b1;
        frame_no++;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("f%0d bit%0d c%0d tx", frame_no, b, c), tx, fb[b]);
                check($sformatf("f%0d bit%0d c%0d busy", frame_no, b, c), busy, 1'b1);
                check($sformatf("f%0d bit%0d c%0d done", frame_no, b, c), done, 1'b0);
                if (b * CPB + c == inject) begin
                    start   = 1'b1;
                    data_in = 8'h3C;
                end else begin
                    start   = 1'b0;
                    data_in = 8'h00;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check($sformatf("f%0d done pulse", frame_no), done, 1'b1);
        check($sformatf("f%0d done-cycle busy", frame_no), busy, 1'b0);
        check($sformatf("f%0d done-cycle tx", frame_no), tx, 1'b1);
        if (chain) begin
            start_pulse(nd);
        end else begin
            @(negedge clk);
            check_idle($sformatf("f%0d after done", frame_no));
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;

        // Reset held 3 cycles, then 20 idle cycles.
        repeat (3) @(negedge clk);
        check_idle("in reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle %0d", i));
        end

        // Single frame 0xA5: tx 0,1,0,1,0,0,1,0,1,1.
        start_pulse(8'hA5);
        check_frame(8'hA5, -1, 1'b0, 8'h00);

        // Start while busy (during data bit 2) is ignored; nothing follows.
        start_pulse(8'hC3);
        check_frame(8'hC3, 13, 1'b0, 8'h00);
        for (int i = 0; i < 2 * CPB * NB; i++) begin
            check_idle($sformatf("no 2nd frame %0d", i));
            @(negedge clk);
        end

        // Back-to-back: 0x5A then 0xFF started in the done cycle.
        start_pulse(8'h5A);
        check_frame(8'h5A, -1, 1'b1, 8'hFF);
        check_frame(8'hFF, -1, 1'b0, 8'h00);

        // Reset during data bit 3 of 0x96 (bit 3 = 0), then a clean frame.
        start_pulse(8'h96);
        repeat (4 * CPB + 1) @(negedge clk);
        check("mid bit3 tx", tx, 1'b0);
        check("mid bit3 busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("after mid reset");
        reset = 1'b0;
        for (int i = 0; i < CPB * NB; i++) begin
            @(negedge clk);
            check_idle($sformatf("post abort %0d", i));
        end
        start_pulse(8'h69);
        check_frame(8'h69, -1, 1'b0, 8'h00);

`ifdef SERIAL_TX_PARITY_EN
        // Parity: 0x07 -> parity 1, 0x03 -> parity 0; 11-bit frames.
        start_pulse(8'h07);
        check_frame(8'h07, -1, 1'b0, 8'h00);
        start_pulse(8'h03);
        check_frame(8'h03, -1, 1'b0, 8'h00);
`endif

        repeat (5) @(negedge clk);
        check_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Serial frame transmitter, directly downstream of the start-pulse generator. It consumes the generator's one-cycle `start` pulse, latches a parallel byte, and shifts it out on a single line as start bit, data LSB-first, optional parity, and stop bit. It reports `busy` during the frame and a one-cycle `done` when the frame ends.

## Interface
- `CLK_PER_BIT`, default 16: clock cycles per serial bit; legal values ≥ 2.
- `DATA_W`, default 8: data bits per frame; legal values 5..9.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request pulse from upstream start generator.
- `data_in`  in  DATA_W  byte to send; sampled only in the cycle `start` is accepted.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse marking frame completion.

## Operation
- States:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = current shift-register LSB.
  - PARITY: only with macro.
  - STOP: `tx`=1.
- Registers:
  - Baud counter `0..CLK_PER_BIT-1`; width ceil(log2(CLK_PER_BIT)).
  - Bit index `0..DATA_W-1`.
  - Shift register, DATA_W bits.
- Every state except IDLE lasts exactly CLK_PER_BIT cycles. The baud counter clears on each state entry and on each DATA bit advance.
- IDLE → START: `start`=1 while in IDLE. `data_in` is latched into the shift register at the same edge.
- `start` while `busy`=1 is ignored, and no data is latched. The block keeps no queue.
- START → DATA when the baud counter reaches CLK_PER_BIT-1.
- DATA:
  - At each bit end the register shifts right and the bit index increments.
  - After bit DATA_W-1 the next state is PARITY, or STOP when the macro is absent.
- STOP → IDLE at baud counter end. At that edge `done` is set to 1; it clears at the following edge.
- `start` in the cycle where `done`=1 is accepted, which gives back-to-back frames.
- Reset, at any time including mid-frame:
  - State goes to IDLE and counters clear.
  - Outputs: `tx`=1, `busy`=0, `done`=0.
  - No done pulse is issued for the aborted frame.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0.
- Latency: `start` sampled at edge k → `tx`=0 and `busy`=1 from edge k+1.
- Frame length, from edge k+1 to IDLE re-entry: (DATA_W+2)·CLK_PER_BIT cycles without parity, (DATA_W+3)·CLK_PER_BIT with parity.
- Data bit i (0 = LSB) is driven during cycles k+1+(1+i)·CLK_PER_BIT through k+(2+i)·CLK_PER_BIT.
- `done` is high for exactly one cycle: the first IDLE cycle after STOP. `busy` is 0 in that same cycle.
- Back-to-back:
  - `start` during the `done` cycle gives at most one idle-high cycle between frames.
  - That idle cycle is the done cycle itself, after which START begins.
- All outputs are glitch-free registered signals; `tx` changes only at bit boundaries.

## Configuration
- Macro `SERIAL_TX_PARITY_EN`.
- Defined:
  - A PARITY state of CLK_PER_BIT cycles is inserted between DATA and STOP.
  - `tx` = even parity, the XOR of the latched DATA_W bits, computed at latch time and held in a register.
- Undefined: DATA goes directly to STOP, and no parity logic or register is present.
- Port list is identical in both builds.

## Test plan
- Reset release: reset held 3 cycles, then idle for 20 cycles → `tx`=1, `busy`=0, `done`=0 throughout.
- Single frame (CLK_PER_BIT=4, DATA_W=8, no parity): `data_in`=0xA5 with a `start` pulse at edge k →
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `busy` high for 40 cycles.
  - `done` high only at cycle k+41.
- Start while busy: a second `start` with `data_in`=0x3C mid-frame → first frame unchanged; no second frame is sent.
- Back-to-back: `start` asserted in the `done` cycle with `data_in`=0xFF → the second frame's start bit begins at the next edge; both frames are bit-exact.
- Reset mid-frame: reset asserted during data bit 3 → `tx`=1 and `busy`=0 after the next edge; no `done`; a following `start` sends a full correct frame.
- With `SERIAL_TX_PARITY_EN`: `data_in`=0x07 → parity bit 1, frame length 44 cycles; `data_in`=0x03 → parity bit 0.
